// File: rtl/eth_tx_sequencer.sv
// rtl/eth_tx_sequencer.sv - Ethernet TX frame sequencer: preamble, SFD, payload, pad, FCS, IFG; ETH_TX_STATS_EN adds frame/byte counters
module eth_tx_sequencer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int MAX_LEN      = 1514,
    parameter int IFG_CYCLES   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [10:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err_len,
    output logic        o_underrun,
    input  logic        i_fifo_empty,
    input  logic [7:0]  i_fifo_data,
    output logic        o_fifo_rd,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
`ifdef ETH_TX_STATS_EN
    ,
    output logic [15:0] o_frame_cnt,
    output logic [31:0] o_byte_cnt
`endif
);

    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0] MIN_L    = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_PAYLOAD,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [10:0] r_len;
    logic [10:0] r_cnt;
    logic [15:0] r_ifg;
    logic [31:0] r_crc;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_underrun_seen;

    logic        w_slot;
    logic        w_load;
    logic [7:0]  w_byte;
    logic [7:0]  w_fcs_byte;
    logic        w_crc_en;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_drop_valid;
    logic        w_ifg_inc;
    logic        w_start_ok;
    logic        w_err_len;
    logic        w_underrun;
    logic        w_fifo_rd;
    logic        w_done;

    // One reflected CRC-32 step over a full byte
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign w_slot = !r_tx_valid || i_tx_ready;

    // FCS goes out least-significant byte first, inverted
    always_comb begin
        w_fcs_byte = 8'h00;
        case (r_cnt[1:0])
            2'd0:    w_fcs_byte = ~r_crc[7:0];
            2'd1:    w_fcs_byte = ~r_crc[15:8];
            2'd2:    w_fcs_byte = ~r_crc[23:16];
            default: w_fcs_byte = ~r_crc[31:24];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle datapath controls
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_byte       = 8'h00;
        w_crc_en     = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_drop_valid = 1'b0;
        w_ifg_inc    = 1'b0;
        w_start_ok   = 1'b0;
        w_err_len    = 1'b0;
        w_underrun   = 1'b0;
        w_fifo_rd    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len > MAX_L) begin
                        w_err_len = 1'b1;
                    end else begin
                        w_start_ok   = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_next_state = S_PREAMBLE;
                    end
                end
            end
            S_PREAMBLE: begin
                if (w_slot) begin
                    w_load = 1'b1;
                    w_byte = 8'h55;
                    if (r_cnt == PRE_LAST) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = S_SFD;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_SFD: begin
                if (w_slot) begin
                    w_load    = 1'b1;
                    w_byte    = 8'hD5;
                    w_cnt_clr = 1'b1;
                    if (r_len != 11'd0) begin
                        w_next_state = S_PAYLOAD;
                    end else if (MIN_L != 11'd0) begin
                        w_next_state = S_PAD;
                    end else begin
                        w_next_state = S_FCS;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_slot) begin
                    if (i_fifo_empty) begin
                        // Starved mid-frame: abort without FCS, still honour the gap
                        w_underrun   = 1'b1;
                        w_drop_valid = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_next_state = S_IFG;
                    end else begin
                        w_load    = 1'b1;
                        w_byte    = i_fifo_data;
                        w_fifo_rd = 1'b1;
                        w_crc_en  = 1'b1;
                        if (r_cnt + 11'd1 == r_len) begin
                            if (r_len < MIN_L) begin
                                w_cnt_inc    = 1'b1;
                                w_next_state = S_PAD;
                            end else begin
                                w_cnt_clr    = 1'b1;
                                w_next_state = S_FCS;
                            end
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
            end
            S_PAD: begin
                if (w_slot) begin
                    w_load   = 1'b1;
                    w_byte   = 8'h00;
                    w_crc_en = 1'b1;
                    if (r_cnt + 11'd1 >= MIN_L) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = S_FCS;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_FCS: begin
                if (w_slot) begin
                    w_load = 1'b1;
                    w_byte = w_fcs_byte;
                    if (r_cnt[1:0] == 2'd3) begin
                        w_cnt_clr    = 1'b1;
                        w_next_state = S_IFG;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_IFG: begin
                if (w_slot) begin
                    w_drop_valid = 1'b1;
                end
                if (!r_tx_valid) begin
                    if (r_ifg == IFG_LAST) begin
                        w_done       = !r_underrun_seen;
                        w_next_state = S_IDLE;
                    end else begin
                        w_ifg_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output byte register, counters, CRC and sticky underrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len           <= 11'd0;
            r_cnt           <= 11'd0;
            r_ifg           <= 16'd0;
            r_crc           <= 32'hFFFFFFFF;
            r_tx_data       <= 8'h00;
            r_tx_valid      <= 1'b0;
            r_underrun_seen <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_len <= i_len;
            end
            if (w_load) begin
                r_tx_data  <= w_byte;
                r_tx_valid <= 1'b1;
            end else if (w_drop_valid) begin
                r_tx_valid <= 1'b0;
            end
            if (w_start_ok) begin
                r_crc <= 32'hFFFFFFFF;
            end else if (w_crc_en) begin
                r_crc <= crc32_byte(r_crc, w_byte);
            end
            if (w_cnt_clr) begin
                r_cnt <= 11'd0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 11'd1;
            end
            r_ifg <= w_ifg_inc ? (r_ifg + 16'd1) : 16'd0;
            if (w_start_ok) begin
                r_underrun_seen <= 1'b0;
            end else if (w_underrun) begin
                r_underrun_seen <= 1'b1;
            end
        end
    end

    // Combinational strobes are suppressed while reset is held so an
    // abandoned frame cannot pop the FIFO in the reset cycle
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = w_done && !rst;
    assign o_err_len  = w_err_len && !rst;
    assign o_underrun = w_underrun && !rst;
    assign o_fifo_rd  = w_fifo_rd && !rst;
    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;

`ifdef ETH_TX_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [31:0] r_byte_cnt;
    logic [10:0] w_body;

    assign w_body = (r_len < MIN_L) ? MIN_L : r_len;

    // Count good frames and their payload+pad+FCS bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
            r_byte_cnt  <= 32'd0;
        end else if (w_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_byte_cnt  <= r_byte_cnt + 32'(w_body) + 32'd4;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_byte_cnt  = r_byte_cnt;
`endif

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// tb/tb_eth_tx_sequencer.sv - directed self-checking bench for eth_tx_sequencer
module tb_eth_tx_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_start0 = 1'b0;
    logic [10:0] i_len = 11'd0;
    logic        i_fifo_empty;
    logic [7:0]  i_fifo_data;
    logic        i_tx_ready = 1'b1;

    logic        o_busy, o_done, o_err_len, o_underrun, o_fifo_rd, o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        o_busy0, o_done0, o_err_len0, o_underrun0, o_fifo_rd0, o_tx_valid0;
    logic [7:0]  o_tx_data0;
`ifdef ETH_TX_STATS_EN
    logic [15:0] frame_cnt, frame_cnt0;
    logic [31:0] byte_cnt, byte_cnt0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eth_tx_sequencer u_dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_err_len(o_err_len), .o_underrun(o_underrun),
        .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_rd(o_fifo_rd),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready)
`ifdef ETH_TX_STATS_EN
        , .o_frame_cnt(frame_cnt), .o_byte_cnt(byte_cnt)
`endif
    );

    eth_tx_sequencer #(.MIN_FRAME(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(i_start0), .i_len(i_len),
        .o_busy(o_busy0), .o_done(o_done0), .o_err_len(o_err_len0), .o_underrun(o_underrun0),
        .i_fifo_empty(i_fifo_empty), .i_fifo_data(i_fifo_data), .o_fifo_rd(o_fifo_rd0),
        .o_tx_data(o_tx_data0), .o_tx_valid(o_tx_valid0), .i_tx_ready(i_tx_ready)
`ifdef ETH_TX_STATS_EN
        , .o_frame_cnt(frame_cnt0), .o_byte_cnt(byte_cnt0)
`endif
    );

    // FWFT FIFO model shared by both instances
    logic [7:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign i_fifo_empty = (rd_ptr >= wr_ptr);
    assign i_fifo_data  = mem[rd_ptr[11:0]];

    always @(posedge clk) begin
        if (o_fifo_rd || o_fifo_rd0) rd_ptr <= rd_ptr + 1;
    end

    // Serializer ready: mode 0 always ready, mode 1 toggles every cycle
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        i_tx_ready = (rdy_mode == 1) ? ~i_tx_ready : 1'b1;
    end

    // Monitor on the falling edge: accepted bytes, pulses, hold violations
    logic       w_v, w_busy;
    logic [7:0] w_d;
    assign w_v    = o_tx_valid | o_tx_valid0;
    assign w_d    = o_tx_valid0 ? o_tx_data0 : o_tx_data;
    assign w_busy = o_busy | o_busy0;

    logic [7:0] cap [0:4095];
    int cap_n = 0, cyc = 0, last_acc_cyc = 0;
    int done_n = 0, done_cyc = 0, under_n = 0, under_cyc = 0, err_n = 0;
    int fall_cyc = 0, hold_viol = 0;
    logic pv = 1'b0, pr = 1'b0, pbusy = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        pbusy <= w_busy;
        if (pbusy && !w_busy) fall_cyc <= cyc;
        if (rst) begin
            pv <= 1'b0;
        end else begin
            if (w_v && i_tx_ready) begin
                cap[cap_n[11:0]] <= w_d;
                cap_n <= cap_n + 1;
                last_acc_cyc <= cyc;
            end
            if (pv && !pr && (!w_v || w_d != pd)) hold_viol <= hold_viol + 1;
            pv <= w_v;
            pr <= i_tx_ready;
            pd <= w_d;
            if (o_done || o_done0) begin
                done_n <= done_n + 1;
                done_cyc <= cyc;
            end
            if (o_underrun || o_underrun0) begin
                under_n <= under_n + 1;
                under_cyc <= cyc;
            end
            if (o_err_len || o_err_len0) err_n <= err_n + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected-frame model
    logic [7:0] exp_b [0:2047];
    int exp_n = 0;

    function automatic logic [31:0] ref_crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r = c;
        logic fb;
        for (int k = 0; k < 8; k++) begin
            fb = r[0] ^ b[k];
            r = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic build_exp(input int first, input int len, input int minf);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [7:0] b;
        int body;
        exp_n = 0;
        for (int i = 0; i < 7; i++) begin
            exp_b[exp_n] = 8'h55;
            exp_n++;
        end
        exp_b[exp_n] = 8'hD5;
        exp_n++;
        body = (len < minf) ? minf : len;
        for (int i = 0; i < body; i++) begin
            b = (i < len) ? mem[first + i] : 8'h00;
            exp_b[exp_n] = b;
            exp_n++;
            c = ref_crc_byte(c, b);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) begin
            exp_b[exp_n] = c[8*i +: 8];
            exp_n++;
        end
    endtask

    function automatic int first_diff(input int bc);
        for (int i = 0; i < exp_n; i++) begin
            if (cap[bc + i] !== exp_b[i]) return i;
        end
        return -1;
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[11:0]] = b;
        wr_ptr++;
    endtask

    task automatic start_frame(input bit sel0, input logic [10:0] len);
        @(posedge clk); #1;
        i_len = len;
        if (sel0) i_start0 = 1'b1;
        else i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_start0 = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < lim) begin
            @(negedge clk);
            n++;
            if (!w_busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_busy, o_tx_valid, o_tx_data, o_fifo_rd, o_done, o_err_len, o_underrun} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {o_busy, o_tx_valid, o_tx_data, o_fifo_rd, o_done, o_err_len, o_underrun});
        end
        checks++;
        if ({o_busy0, o_tx_valid0, o_tx_data0, o_fifo_rd0, o_done0, o_err_len0, o_underrun0} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs_min0: got %b expected all zero",
                     {o_busy0, o_tx_valid0, o_tx_data0, o_fifo_rd0, o_done0, o_err_len0, o_underrun0});
        end
    endtask

    task automatic test_check_vector();
        logic [7:0] v [0:20];
        int bc, br, bd, fd;
        bit ok;
        v = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
              8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        rdy_mode = 0;
        bc = cap_n; br = rd_ptr; bd = done_n;
        for (int i = 0; i < 9; i++) push(8'h31 + 8'(i));
        start_frame(1'b1, 11'd9);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t1_timeout: busy still high after 200 cycles"); end
        exp_n = 21;
        for (int i = 0; i < 21; i++) exp_b[i] = v[i];
        checks++;
        if (cap_n - bc != 21) begin errors++; $display("FAIL t1_count: got %0d bytes expected 21", cap_n - bc); end
        fd = first_diff(bc);
        checks++;
        if (fd >= 0) begin errors++; $display("FAIL t1_bytes: byte %0d got %h expected %h", fd, cap[bc+fd], exp_b[fd]); end
        checks++;
        if (rd_ptr - br != 9) begin errors++; $display("FAIL t1_pops: got %0d expected 9", rd_ptr - br); end
        checks++;
        if (done_n - bd != 1) begin errors++; $display("FAIL t1_done: got %0d pulses expected 1", done_n - bd); end
        checks++;
        if (done_cyc - last_acc_cyc != 12) begin
            errors++; $display("FAIL t1_ifg: done %0d cycles after last byte expected 12", done_cyc - last_acc_cyc);
        end
    endtask

    task automatic test_pad();
        int bc, br, bd, fd, first;
        bit ok;
        rdy_mode = 0;
        bc = cap_n; br = rd_ptr; bd = done_n; first = rd_ptr;
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        build_exp(first, 10, 60);
        start_frame(1'b0, 11'd10);
        wait_idle(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t2_timeout: busy still high after 300 cycles"); end
        checks++;
        if (cap_n - bc != 72) begin errors++; $display("FAIL t2_count: got %0d bytes expected 72", cap_n - bc); end
        fd = first_diff(bc);
        checks++;
        if (fd >= 0) begin errors++; $display("FAIL t2_bytes: byte %0d got %h expected %h", fd, cap[bc+fd], exp_b[fd]); end
        checks++;
        if (rd_ptr - br != 10) begin errors++; $display("FAIL t2_pops: got %0d expected 10", rd_ptr - br); end
        checks++;
        if (done_n - bd != 1) begin errors++; $display("FAIL t2_done: got %0d pulses expected 1", done_n - bd); end
`ifdef ETH_TX_STATS_EN
        checks++;
        if (frame_cnt !== 16'd1 || byte_cnt !== 32'd64) begin
            errors++; $display("FAIL t2_stats: got frames=%0d bytes=%0d expected 1 and 64", frame_cnt, byte_cnt);
        end
`endif
    endtask

    task automatic test_backpressure();
        int bc, br, bd, bh, fd, first;
        bit ok;
        rdy_mode = 1;
        bc = cap_n; br = rd_ptr; bd = done_n; bh = hold_viol; first = rd_ptr;
        for (int i = 0; i < 64; i++) push(8'(i * 7 + 3));
        build_exp(first, 64, 60);
        start_frame(1'b0, 11'd64);
        wait_idle(600, ok);
        rdy_mode = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL t3_timeout: busy still high after 600 cycles"); end
        checks++;
        if (cap_n - bc != 76) begin errors++; $display("FAIL t3_count: got %0d bytes expected 76", cap_n - bc); end
        fd = first_diff(bc);
        checks++;
        if (fd >= 0) begin errors++; $display("FAIL t3_bytes: byte %0d got %h expected %h", fd, cap[bc+fd], exp_b[fd]); end
        checks++;
        if (rd_ptr - br != 64) begin errors++; $display("FAIL t3_pops: got %0d expected 64", rd_ptr - br); end
        checks++;
        if (hold_viol - bh != 0) begin errors++; $display("FAIL t3_hold: got %0d stalled-byte changes expected 0", hold_viol - bh); end
        checks++;
        if (done_n - bd != 1) begin errors++; $display("FAIL t3_done: got %0d pulses expected 1", done_n - bd); end
    endtask

    task automatic test_underrun();
        int bc, br, bd, bu, fd, first;
        bit ok;
        rdy_mode = 0;
        bc = cap_n; br = rd_ptr; bd = done_n; bu = under_n; first = rd_ptr;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        build_exp(first, 5, 0);
        exp_n = 13;
        start_frame(1'b0, 11'd20);
        wait_idle(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t4_timeout: busy still high after 200 cycles"); end
        checks++;
        if (cap_n - bc != 13) begin errors++; $display("FAIL t4_count: got %0d bytes expected 13", cap_n - bc); end
        fd = first_diff(bc);
        checks++;
        if (fd >= 0) begin errors++; $display("FAIL t4_bytes: byte %0d got %h expected %h", fd, cap[bc+fd], exp_b[fd]); end
        checks++;
        if (under_n - bu != 1) begin errors++; $display("FAIL t4_underrun: got %0d pulses expected 1", under_n - bu); end
        checks++;
        if (done_n - bd != 0) begin errors++; $display("FAIL t4_done: got %0d pulses expected 0", done_n - bd); end
        checks++;
        if (rd_ptr - br != 5) begin errors++; $display("FAIL t4_pops: got %0d expected 5", rd_ptr - br); end
        checks++;
        if (fall_cyc - under_cyc != 13) begin
            errors++; $display("FAIL t4_busy_fall: busy low %0d cycles after underrun expected 13", fall_cyc - under_cyc);
        end
`ifdef ETH_TX_STATS_EN
        checks++;
        if (frame_cnt !== 16'd2 || byte_cnt !== 32'd132) begin
            errors++; $display("FAIL t4_stats: got frames=%0d bytes=%0d expected 2 and 132", frame_cnt, byte_cnt);
        end
`endif
    endtask

    task automatic test_start_rules();
        int bc, br, bd, be, fd, first, after;
        bit ok;
        rdy_mode = 0;
        be = err_n;
        start_frame(1'b0, 11'd1515);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_busy !== 1'b0) begin errors++; $display("FAIL t5_reject_busy: got %b expected 0", o_busy); end
        end
        @(posedge clk); #1;
        checks++;
        if (err_n - be != 1) begin errors++; $display("FAIL t5_err_len: got %0d pulses expected 1", err_n - be); end
        bc = cap_n; br = rd_ptr; bd = done_n; be = err_n; first = rd_ptr;
        for (int i = 0; i < 64; i++) push(8'hFF - 8'(i));
        build_exp(first, 64, 60);
        start_frame(1'b0, 11'd64);
        repeat (20) @(posedge clk);
        #1;
        i_len = 11'd5;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_idle(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t5_timeout: busy still high after 300 cycles"); end
        after = cap_n;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (cap_n - bc != 76) begin errors++; $display("FAIL t5_count: got %0d bytes expected 76", cap_n - bc); end
        fd = first_diff(bc);
        checks++;
        if (fd >= 0) begin errors++; $display("FAIL t5_bytes: byte %0d got %h expected %h", fd, cap[bc+fd], exp_b[fd]); end
        checks++;
        if (rd_ptr - br != 64 || done_n - bd != 1 || err_n - be != 0) begin
            errors++;
            $display("FAIL t5_busy_start: got pops=%0d done=%0d err=%0d expected 64 1 0", rd_ptr - br, done_n - bd, err_n - be);
        end
        checks++;
        if (cap_n != after || o_busy !== 1'b0) begin
            errors++; $display("FAIL t5_no_second: got %0d extra bytes busy=%b expected 0 and 0", cap_n - after, o_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bc, br, bd, fd, first, n;
        bit ok;
        rdy_mode = 0;
        first = rd_ptr; bd = done_n;
        for (int i = 0; i < 64; i++) push(8'h40 + 8'(i));
        start_frame(1'b0, 11'd64);
        n = 0;
        while (rd_ptr - first < 30 && n < 300) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_busy, o_tx_valid, o_tx_data, o_fifo_rd, o_done, o_err_len, o_underrun} !== 14'd0) begin
            errors++;
            $display("FAIL t6_reset_outputs: got %b expected all zero",
                     {o_busy, o_tx_valid, o_tx_data, o_fifo_rd, o_done, o_err_len, o_underrun});
        end
        checks++;
        if (rd_ptr - first != 30) begin errors++; $display("FAIL t6_abort_pops: got %0d expected 30", rd_ptr - first); end
        bc = cap_n; br = rd_ptr;
        build_exp(rd_ptr, 4, 60);
        start_frame(1'b0, 11'd4);
        wait_idle(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t6_timeout: busy still high after 300 cycles"); end
        checks++;
        if (cap_n - bc != 72) begin errors++; $display("FAIL t6_count: got %0d bytes expected 72", cap_n - bc); end
        fd = first_diff(bc);
        checks++;
        if (fd >= 0) begin errors++; $display("FAIL t6_bytes: byte %0d got %h expected %h", fd, cap[bc+fd], exp_b[fd]); end
        checks++;
        if (rd_ptr - br != 4) begin errors++; $display("FAIL t6_pops: got %0d expected 4", rd_ptr - br); end
        checks++;
        if (done_n - bd != 1) begin errors++; $display("FAIL t6_done: got %0d pulses expected 1", done_n - bd); end
    endtask

    initial begin
        test_reset();
        test_check_vector();
        test_pad();
        test_backpressure();
        test_underrun();
        test_start_rules();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
